// File: rtl/rc4_engine.sv
// RC4 decryption engine: S-box init, key scheduling and keystream XOR over an
// encrypted message, driving external single-port S RAM, message ROM and plaintext RAM.
module rc4_engine #(
  parameter int KEY_BYTES  = 3,
  parameter int MSG_LEN    = 32,
  parameter bit CHECK_TEXT = 1'b1,
  localparam int MA        = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rdata,
  output logic [MA-1:0]          m_addr,
  input  logic [7:0]             m_rdata,
  output logic [MA-1:0]          d_addr,
  output logic [7:0]             d_wdata,
  output logic                   d_wren,
  output logic [2:0]             state_dbg
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  // Handshake: start is sampled only in IDLE; busy rises the cycle after accept,
  // done pulses for one cycle with busy low, and pass stays valid until the next accept.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    KSA  = 3'd2,
    PRGA = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                 state;
  logic [2:0]             sub;
  logic [7:0]             i, j, si, sj;
  logic [MA-1:0]          k;
  logic [KW-1:0]          kidx;
  logic [8*KEY_BYTES-1:0] key_r;

  logic [7:0] key_byte, j_ksa, j_prga, plain;
  logic       plain_ok, abort;

  assign state_dbg = state;

  always_comb begin
    key_byte = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++)
      if (kidx == KW'(b)) key_byte = key_r[8*(KEY_BYTES-1-b) +: 8];
  end

  // New j is needed in the same cycle the S[i] read data arrives, so it is formed from s_rdata.
  assign j_ksa    = j + s_rdata + key_byte;
  assign j_prga   = j + s_rdata;
  assign plain    = s_rdata ^ m_rdata;
  assign plain_ok = (plain == 8'h20) || ((plain >= 8'h61) && (plain <= 8'h7A));
  assign abort    = CHECK_TEXT && !plain_ok;

  always_comb begin
    s_addr  = 8'h00;
    s_wdata = 8'h00;
    s_wren  = 1'b0;
    m_addr  = '0;
    d_addr  = '0;
    d_wdata = 8'h00;
    d_wren  = 1'b0;
    case (state)
      INIT: begin
        s_addr  = i;
        s_wdata = i;
        s_wren  = 1'b1;
      end
      KSA: begin
        case (sub)
          3'd0: s_addr = i;
          3'd1: s_addr = j_ksa;
          3'd3: begin
            s_addr  = i;
            s_wdata = sj;
            s_wren  = 1'b1;
          end
          3'd4: begin
            s_addr  = j;
            s_wdata = si;
            s_wren  = 1'b1;
          end
          default: ;
        endcase
      end
      PRGA: begin
        case (sub)
          3'd0: s_addr = i + 8'd1;
          3'd1: s_addr = j_prga;
          3'd2: begin
            s_addr  = i;
            s_wdata = s_rdata;
            s_wren  = 1'b1;
          end
          3'd3: begin
            s_addr  = j;
            s_wdata = si;
            s_wren  = 1'b1;
          end
          3'd4: begin
            s_addr = si + sj;
            m_addr = k;
          end
          3'd5: begin
            d_addr  = k;
            d_wdata = plain;
            d_wren  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sub   <= 3'd0;
      i     <= 8'h00;
      j     <= 8'h00;
      si    <= 8'h00;
      sj    <= 8'h00;
      k     <= '0;
      kidx  <= '0;
      key_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= INIT;
            key_r <= key;
            i     <= 8'h00;
            j     <= 8'h00;
            sub   <= 3'd0;
            kidx  <= '0;
            busy  <= 1'b1;
            pass  <= 1'b0;
          end
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == 8'hFF) begin
            state <= KSA;
            sub   <= 3'd0;
          end
        end
        KSA: begin
          case (sub)
            3'd1: begin
              si  <= s_rdata;
              j   <= j_ksa;
              sub <= 3'd2;
            end
            3'd2: begin
              sj  <= s_rdata;
              sub <= 3'd3;
            end
            3'd4: begin
              sub  <= 3'd0;
              i    <= i + 8'd1;
              kidx <= (kidx == KW'(KEY_BYTES-1)) ? '0 : kidx + 1'b1;
              // i wraps to 0 on its own, which is the PRGA starting value.
              if (i == 8'hFF) begin
                state <= PRGA;
                j     <= 8'h00;
                k     <= '0;
              end
            end
            default: sub <= sub + 3'd1;
          endcase
        end
        PRGA: begin
          case (sub)
            3'd0: begin
              i   <= i + 8'd1;
              sub <= 3'd1;
            end
            3'd1: begin
              si  <= s_rdata;
              j   <= j_prga;
              sub <= 3'd2;
            end
            3'd2: begin
              sj  <= s_rdata;
              sub <= 3'd3;
            end
            3'd5: begin
              sub <= 3'd0;
              if (abort || (k == MA'(MSG_LEN-1))) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= !abort;
              end else begin
                k <= k + 1'b1;
              end
            end
            default: sub <= sub + 3'd1;
          endcase
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_engine.sv
// Bench for rc4_engine: three configurations share one clock, each with its own
// synchronous memory models; plaintext writes are scored against an expected queue.
module tb_rc4_engine;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // configuration A: key 3, msg 9, no check; B: key 3, msg 9, check; C: key 4, msg 5, check
  logic        start_a, start_b, start_c;
  logic [23:0] key_a, key_b;
  logic [31:0] key_c;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic [7:0]  s_addr_a, s_wdata_a, s_rdata_a, s_addr_b, s_wdata_b, s_rdata_b;
  logic [7:0]  s_addr_c, s_wdata_c, s_rdata_c;
  logic        s_wren_a, s_wren_b, s_wren_c, d_wren_a, d_wren_b, d_wren_c;
  logic [3:0]  m_addr_a, d_addr_a, m_addr_b, d_addr_b;
  logic [2:0]  m_addr_c, d_addr_c;
  logic [7:0]  m_rdata_a, m_rdata_b, m_rdata_c, d_wdata_a, d_wdata_b, d_wdata_c;
  logic [2:0]  st_a, st_b, st_c;

  logic [7:0] s_mem_a [256];
  logic [7:0] s_mem_b [256];
  logic [7:0] s_mem_c [256];
  logic [7:0] rom9 [16];
  logic [7:0] rom5 [8];

  logic [7:0] exp_q[$];
  logic [7:0] exp_addr_q[$];
  logic [7:0] ref_s [256];
  logic [7:0] ref_ks [256];

  int         sel;
  logic       busy_s, done_s, pass_s, d_wren_s;
  logic [7:0] d_addr_s, d_wdata_s;
  int         len_s;

  rc4_engine #(.KEY_BYTES(3), .MSG_LEN(9), .CHECK_TEXT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .key(key_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a), .s_rdata(s_rdata_a),
    .m_addr(m_addr_a), .m_rdata(m_rdata_a),
    .d_addr(d_addr_a), .d_wdata(d_wdata_a), .d_wren(d_wren_a), .state_dbg(st_a)
  );

  rc4_engine #(.KEY_BYTES(3), .MSG_LEN(9), .CHECK_TEXT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .key(key_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b), .s_rdata(s_rdata_b),
    .m_addr(m_addr_b), .m_rdata(m_rdata_b),
    .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_wren(d_wren_b), .state_dbg(st_b)
  );

  rc4_engine #(.KEY_BYTES(4), .MSG_LEN(5), .CHECK_TEXT(1'b1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .key(key_c),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .s_addr(s_addr_c), .s_wdata(s_wdata_c), .s_wren(s_wren_c), .s_rdata(s_rdata_c),
    .m_addr(m_addr_c), .m_rdata(m_rdata_c),
    .d_addr(d_addr_c), .d_wdata(d_wdata_c), .d_wren(d_wren_c), .state_dbg(st_c)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous memories, read latency 1, write visible to the next read
  always @(posedge clk) begin
    if (s_wren_a) s_mem_a[s_addr_a] <= s_wdata_a;
    if (s_wren_b) s_mem_b[s_addr_b] <= s_wdata_b;
    if (s_wren_c) s_mem_c[s_addr_c] <= s_wdata_c;
    s_rdata_a <= s_mem_a[s_addr_a];
    s_rdata_b <= s_mem_b[s_addr_b];
    s_rdata_c <= s_mem_c[s_addr_c];
    m_rdata_a <= rom9[m_addr_a];
    m_rdata_b <= rom9[m_addr_b];
    m_rdata_c <= rom5[m_addr_c];
  end

  always_comb begin
    busy_s = busy_a; done_s = done_a; pass_s = pass_a;
    d_wren_s = d_wren_a; d_addr_s = {4'h0, d_addr_a}; d_wdata_s = d_wdata_a; len_s = 9;
    case (sel)
      1: begin
        busy_s = busy_b; done_s = done_b; pass_s = pass_b;
        d_wren_s = d_wren_b; d_addr_s = {4'h0, d_addr_b}; d_wdata_s = d_wdata_b; len_s = 9;
      end
      2: begin
        busy_s = busy_c; done_s = done_c; pass_s = pass_c;
        d_wren_s = d_wren_c; d_addr_s = {5'h00, d_addr_c}; d_wdata_s = d_wdata_c; len_s = 5;
      end
      default: ;
    endcase
  end

  // scoreboard: pop one expected byte per plaintext RAM write of the selected engine
  always @(negedge clk) begin
    logic [7:0] e_d, e_a;
    if (d_wren_s) begin
      checks++;
      if (int'(d_addr_s) >= len_s) begin
        failures++;
        $display("FAIL d_addr_range: got %0d, need < %0d", d_addr_s, len_s);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL extra_write: got addr %0d data %02h, no write expected", d_addr_s, d_wdata_s);
      end else begin
        e_d = exp_q.pop_front();
        e_a = exp_addr_q.pop_front();
        if (d_wdata_s !== e_d || d_addr_s !== e_a) begin
          failures++;
          $display("FAIL d_write: got addr %0d data %02h, need addr %0d data %02h",
                   d_addr_s, d_wdata_s, e_a, e_d);
        end
      end
    end
    if ((sel != 0 && (s_wren_a || d_wren_a)) || (sel != 1 && (s_wren_b || d_wren_b)) ||
        (sel != 2 && (s_wren_c || d_wren_c))) begin
      checks++;
      failures++;
      $display("FAIL stray_write: idle engine wrote (sel=%0d a=%b%b b=%b%b c=%b%b)", sel,
               s_wren_a, d_wren_a, s_wren_b, d_wren_b, s_wren_c, d_wren_c);
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  // driver: pulse (or hold) start, count busy cycles until done, then one cycle past done
  task automatic run_dut(input int which, input logic [31:0] key_v, input bit spam,
                         output int busy_cnt, output int done_cnt, output bit timeout);
    sel = which;
    case (which)
      0: key_a = key_v[23:0];
      1: key_b = key_v[23:0];
      default: key_c = key_v;
    endcase
    set_start(which, 1'b1);
    @(negedge clk);
    if (!spam) set_start(which, 1'b0);
    busy_cnt = 0;
    done_cnt = 0;
    timeout  = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (done_s) begin
        done_cnt++;
        timeout = 1'b0;
        break;
      end
      if (busy_s) busy_cnt++;
      if (spam) begin
        key_a = 24'($urandom);
        key_c = $urandom;
      end
      @(negedge clk);
    end
    set_start(which, 1'b0);
    @(negedge clk);
    if (done_s) done_cnt++;
  endtask

  task automatic ref_keystream(input logic [127:0] key_v, input int klen, input int n);
    int jj, ii;
    logic [7:0] t, kb;
    for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      kb = key_v[8*(klen-1-(x%klen)) +: 8];
      jj = (jj + int'(ref_s[x]) + int'(kb)) % 256;
      t = ref_s[x]; ref_s[x] = ref_s[jj]; ref_s[jj] = t;
    end
    ii = 0;
    jj = 0;
    for (int x = 0; x < n; x++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(ref_s[ii])) % 256;
      t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
      ref_ks[x] = ref_s[(int'(ref_s[ii]) + int'(ref_s[jj])) % 256];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, done_a, pass_a, s_addr_a, s_wdata_a, s_wren_a, m_addr_a, d_addr_a, d_wdata_a,
         d_wren_a, st_a} !== '0) begin
      failures++;
      $display("FAIL reset_a: got busy=%b done=%b pass=%b s_addr=%02h s_wren=%b d_wren=%b state=%0d, need all 0",
               busy_a, done_a, pass_a, s_addr_a, s_wren_a, d_wren_a, st_a);
    end
    checks++;
    if ({busy_b, done_b, pass_b, s_addr_b, s_wdata_b, s_wren_b, m_addr_b, d_addr_b, d_wdata_b,
         d_wren_b, st_b} !== '0) begin
      failures++;
      $display("FAIL reset_b: got busy=%b done=%b pass=%b s_wren=%b d_wren=%b state=%0d, need all 0",
               busy_b, done_b, pass_b, s_wren_b, d_wren_b, st_b);
    end
    checks++;
    if ({busy_c, done_c, pass_c, s_addr_c, s_wdata_c, s_wren_c, m_addr_c, d_addr_c, d_wdata_c,
         d_wren_c, st_c} !== '0) begin
      failures++;
      $display("FAIL reset_c: got busy=%b done=%b pass=%b s_wren=%b d_wren=%b state=%0d, need all 0",
               busy_c, done_c, pass_c, s_wren_c, d_wren_c, st_c);
    end
  endtask

  task automatic check_run(input string name, input int bc, input int dc, input bit to,
                           input int exp_busy, input logic exp_pass);
    checks++;
    if (to || bc != exp_busy) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d (timeout=%b), need %0d", name, bc, to, exp_busy);
    end
    checks++;
    if (dc != 1) begin
      failures++;
      $display("FAIL %s_done_pulses: got %0d, need 1", name, dc);
    end
    checks++;
    if (pass_s !== exp_pass) begin
      failures++;
      $display("FAIL %s_pass: got %b, need %b", name, pass_s, exp_pass);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes: got %0d writes outstanding, need 0", name, exp_q.size());
    end
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic push_plaintext();
    logic [71:0] txt;
    txt = 72'h50_6C_61_69_6E_74_65_78_74;
    for (int x = 0; x < 9; x++) push_exp(8'(x), txt[8*(8-x) +: 8]);
  endtask

  task automatic test_key_plain();
    int bc, dc;
    bit to;
    push_plaintext();
    run_dut(0, 32'h004B6579, 1'b0, bc, dc, to);
    check_run("key_plain", bc, dc, to, 1590, 1'b1);
  endtask

  task automatic test_check_abort();
    int bc, dc;
    bit to;
    push_exp(8'd0, 8'h50);
    run_dut(1, 32'h004B6579, 1'b0, bc, dc, to);
    check_run("check_abort", bc, dc, to, 1542, 1'b0);
  endtask

  task automatic test_wiki();
    int bc, dc;
    bit to;
    logic [39:0] txt;
    txt = 40'h70_65_64_69_61;
    for (int x = 0; x < 5; x++) push_exp(8'(x), txt[8*(4-x) +: 8]);
    run_dut(2, 32'h57696B69, 1'b0, bc, dc, to);
    check_run("wiki", bc, dc, to, 1566, 1'b1);
  endtask

  task automatic test_start_spam();
    int bc, dc;
    bit to;
    push_plaintext();
    run_dut(0, 32'h004B6579, 1'b1, bc, dc, to);
    check_run("start_spam", bc, dc, to, 1590, 1'b1);
  endtask

  task automatic test_back_to_back_new_key();
    int bc, dc;
    bit to;
    logic [23:0] nk;
    nk = 24'(($urandom_range(1, 255) << 16) | $urandom_range(0, 65535));
    if (nk == 24'h4B6579) nk = 24'hA53C0F;
    ref_keystream({104'h0, nk}, 3, 9);
    for (int x = 0; x < 9; x++) push_exp(8'(x), rom9[x] ^ ref_ks[x]);
    run_dut(0, {8'h00, nk}, 1'b0, bc, dc, to);
    check_run("new_key", bc, dc, to, 1590, 1'b1);
  endtask

  task automatic test_mid_reset();
    int bc, dc;
    bit to;
    bit quiet;
    sel = 0;
    key_a = 24'h4B6579;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (700) @(negedge clk);
    checks++;
    if (st_a !== 3'd2) begin
      failures++;
      $display("FAIL mid_reset_in_ksa: got state %0d, need 2", st_a);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy_a, done_a, pass_a, s_addr_a, s_wdata_a, s_wren_a, m_addr_a, d_addr_a, d_wdata_a,
         d_wren_a, st_a} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got busy=%b s_addr=%02h s_wren=%b state=%0d, need all 0",
               busy_a, s_addr_a, s_wren_a, st_a);
    end
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy_a || s_wren_a || d_wren_a || done_a) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL mid_reset_quiet: got activity after reset, need none");
    end
    push_plaintext();
    run_dut(0, 32'h004B6579, 1'b0, bc, dc, to);
    check_run("after_reset", bc, dc, to, 1590, 1'b1);
  endtask

  initial begin
    logic [71:0] c9;
    logic [39:0] c5;
    checks   = 0;
    failures = 0;
    sel      = 0;
    reset    = 1'b1;
    start_a  = 1'b0; start_b = 1'b0; start_c = 1'b0;
    key_a    = 24'h0; key_b = 24'h0; key_c = 32'h0;
    c9 = 72'hBB_F3_16_E8_D9_40_AF_0A_D3;
    c5 = 40'h10_21_BF_04_20;
    for (int x = 0; x < 16; x++) rom9[x] = (x < 9) ? c9[8*(8-x) +: 8] : 8'h00;
    for (int x = 0; x < 8; x++) rom5[x] = (x < 5) ? c5[8*(4-x) +: 8] : 8'h00;
    @(negedge clk);
    test_reset();
    test_key_plain();
    test_check_abort();
    test_wiki();
    test_start_spam();
    test_back_to_back_new_key();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
